spart_tx_fifo: RTL and testbench

Transmit side of the SPART, directly downstream of the processor's send port. It accepts bytes on `send`/`send_data`, buffers them in a small FIFO, and serialises them onto `TxD` as 8N1 UART frames. It drives `full` back to the processor, whose stall controller holds the pipeline while `send` is pending and `full` is high.

---
 rtl/spart_tx_fifo.sv | 169 ++++++++++++++++
 tb/tb_spart_tx_fifo.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/spart_tx_fifo.sv
// SPART transmitter: byte FIFO feeding an 8N1 UART serialiser onto TxD.
// Latency: push at edge N pops from idle at N+1, so TxD falls after N+1; a frame lasts 10*BAUD_DIV cycles.
// Backpressure: full is high at DEPTH entries; a push while full is silently dropped and the sender holds send.
module spart_tx_fifo #(
    parameter int          DEPTH    = 8,
    parameter logic [15:0] BAUD_DIV = 16'd434
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     send,
    input  logic [7:0]               send_data,
    output logic                     full,
    output logic                     TxD,
    output logic                     tx_busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int              AW        = $clog2(DEPTH);
    localparam int              CW        = AW + 1;
    localparam logic [CW-1:0]   FULL_CNT  = CW'(DEPTH);
    localparam logic [15:0]     BAUD_LAST = BAUD_DIV - 16'd1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    state_t        state_q, state_d;
    logic [15:0]   baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;

    logic          push;
    logic          pop;
    logic          baud_end;
    logic [7:0]    head;

    // full comes from the registered count, so a same-cycle pop never frees room for a push
    assign full     = (count_q == FULL_CNT);
    assign push     = send & ~full;
    assign head     = mem_q[rd_ptr_q];
    assign baud_end = (baud_q == BAUD_LAST);

    assign count    = count_q;
    assign TxD      = txd_q;
    assign tx_busy  = (state_q != S_IDLE);

    // FIFO storage: written on accepted pushes, deliberately not reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= send_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); occupancy tracked separately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Serialiser state registers; TxD is registered so the line never glitches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

    // Next-state: TxD is computed one cycle ahead so it lines up with the state it belongs to
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = head;
                    baud_d  = '0;
                    state_d = S_START;
                    txd_d   = 1'b0;
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                    txd_d   = shift_q[0];
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        txd_d = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (count_q != '0) begin
                        // back-to-back frame: no idle gap after the stop bit
                        pop     = 1'b1;
                        shift_d = head;
                        state_d = S_START;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        txd_d   = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_spart_tx_fifo.sv
// Bench for spart_tx_fifo: directed pushes feed an expected-byte queue, a UART receiver pops and compares.
// Latency: checks first-frame start one edge after the push and exact 10*BAUD_DIV frame spacing.
// Backpressure: exercises full, dropped pushes, simultaneous push/pop and async reset mid-frame.
module tb_spart_tx_fifo;

    localparam int          DEPTH    = 8;
    localparam logic [15:0] BAUD_DIV = 16'd4;

    logic       clk;
    logic       rst;
    logic       send;
    logic [7:0] send_data;
    logic       full;
    logic       TxD;
    logic       tx_busy;
    logic [3:0] count;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int rx_phase = -1;
    int rx_done  = 0;
    logic [7:0] rx_byte;
    logic [7:0] exp_q[$];
    int start_times[$];

    spart_tx_fifo #(.DEPTH(DEPTH), .BAUD_DIV(BAUD_DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .send      (send),
        .send_data (send_data),
        .full      (full),
        .TxD       (TxD),
        .tx_busy   (tx_busy),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Receiver/monitor: samples TxD mid-bit on the falling clock edge and checks against the queue
    always @(negedge clk) begin
        if (rst) begin
            rx_phase = -1;
        end else if (rx_phase < 0) begin
            if (TxD === 1'b0) begin
                rx_phase = 0;
                start_times.push_back(cyc);
            end
        end else begin
            rx_phase++;
            if (rx_phase == 1) begin
                check("rx_start_bit", TxD, 1'b0);
            end else if (rx_phase >= 5 && rx_phase <= 33 && (rx_phase % 4) == 1) begin
                rx_byte[(rx_phase - 5) / 4] = TxD;
            end else if (rx_phase == 37) begin
                check("rx_stop_bit", TxD, 1'b1);
                check("rx_expected_pending", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    check("rx_byte", rx_byte, exp_q.pop_front());
                end
                rx_done++;
            end
            if (rx_phase == 39) begin
                rx_phase = -1;
            end
        end
    end

    // Drive one push for a single cycle; called just after a rising edge, returns just after the next
    task automatic push_byte(input logic [7:0] b, input bit accepted);
        send      = 1'b1;
        send_data = b;
        @(posedge clk);
        #1;
        send = 1'b0;
        if (accepted) exp_q.push_back(b);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((count != 0 || tx_busy || rx_phase >= 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_in_time", n < budget, 1'b1);
    endtask

    initial begin
        int busy;
        int idx0;
        int bad;
        rst       = 1'b1;
        send      = 1'b0;
        send_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_txd", TxD, 1'b1);
        check("reset_full", full, 1'b0);
        check("reset_busy", tx_busy, 1'b0);
        check("reset_count", count, 4'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // single byte 0xA5
        push_byte(8'hA5, 1'b1);
        check("single_count_after_push", count, 4'd1);
        check("single_txd_before_pop", TxD, 1'b1);
        @(posedge clk);
        #1;
        check("single_txd_falls", TxD, 1'b0);
        check("single_busy_rises", tx_busy, 1'b1);
        check("single_count_after_pop", count, 4'd0);
        busy = 1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (!tx_busy) break;
            busy++;
        end
        check("single_busy_cycles", busy, 40);
        check("single_txd_idle", TxD, 1'b1);
        wait_drain(50);

        // fill to full, then a dropped push
        idx0 = start_times.size();
        for (int i = 0; i < 9; i++) begin
            push_byte(8'(i), 1'b1);
        end
        check("fill_full", full, 1'b1);
        check("fill_count", count, 4'd8);
        push_byte(8'h09, 1'b0);
        check("fill_drop_count", count, 4'd8);
        check("fill_drop_full", full, 1'b1);
        wait_drain(9 * 40 + 60);
        check("fill_frames", start_times.size() - idx0, 9);
        for (int i = 1; i < 9; i++) begin
            if (idx0 + i < start_times.size())
                check("fill_b2b_spacing", start_times[idx0 + i] - start_times[idx0 + i - 1], 40);
        end

        // simultaneous push and pop at STOP->START with count 3
        push_byte(8'h31, 1'b1);
        push_byte(8'h32, 1'b1);
        push_byte(8'h33, 1'b1);
        push_byte(8'h34, 1'b1);
        check("simul_count_before", count, 4'd3);
        repeat (37) @(posedge clk);
        #1;
        check("simul_in_stop", TxD, 1'b1);
        push_byte(8'h35, 1'b1);
        check("simul_count_after", count, 4'd3);
        check("simul_next_start", TxD, 1'b0);
        check("simul_busy", tx_busy, 1'b1);
        wait_drain(5 * 40 + 60);

        // pointer wrap: 20 bytes, occupancy kept at or below 6
        for (int i = 0; i < 20; i++) begin
            int w;
            w = 0;
            while (count >= 6 && w < 100) begin
                @(posedge clk);
                #1;
                w++;
            end
            check("wrap_room", count < 6, 1'b1);
            push_byte(8'(8'h10 + i), 1'b1);
        end
        wait_drain(20 * 40 + 60);

        // async reset during DATA bit 3 with two bytes queued
        push_byte(8'hC3, 1'b1);
        push_byte(8'h3C, 1'b1);
        push_byte(8'h77, 1'b1);
        repeat (16) @(posedge clk);
        #1;
        check("midframe_count", count, 4'd2);
        check("midframe_busy", tx_busy, 1'b1);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("arst_txd", TxD, 1'b1);
        check("arst_busy", tx_busy, 1'b0);
        check("arst_count", count, 4'd0);
        check("arst_full", full, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (TxD !== 1'b1) bad++;
        end
        check("post_reset_idle_line", bad, 0);

        // resume after reset
        push_byte(8'h5A, 1'b1);
        @(posedge clk);
        #1;
        check("resume_start", TxD, 1'b0);
        wait_drain(100);

        check("all_expected_received", exp_q.size(), 0);
        check("frames_received", rx_done, 36);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule
